// File: rtl/wb_spi_arbiter.sv
// wb_spi_arbiter
// Round-robin Wishbone arbiter that shares one SPI memory controller slave
// port (24-bit address, 8-bit data) between NUM_MASTERS requesters.
//
// Ports:
//   clk_i, rst_ni          clock (rising edge), asynchronous active-low reset
//   m_cyc_i/m_stb_i/m_we_i per-master cycle, strobe, write enable
//   m_adr_i, m_dat_i       per-master address (24 b) and write data (8 b), packed
//   m_ack_o, m_err_o       per-master ack and error (slave error or watchdog abort)
//   m_dat_o                slave read data broadcast to every master
//   s_*_o, s_*_i           Wishbone master side towards the SPI controller
//   dbg_state_o            FSM state (0 IDLE, 1 GRANT, 2 ABORT)
//   dbg_gnt_o, dbg_wd_o    current grant index and watchdog count
//
// Handshake: a master owns the slave from the cycle after arbitration until it
// drops cyc. While owned, cyc/stb/we/adr/dat pass straight through and the
// slave's ack/err go back to the owner only; a transfer completes in the
// cycle where stb and ack are both high. Stalled strobes are ended by the
// watchdog with a one-cycle err pulse followed by one cycle with cyc low.
module wb_spi_arbiter #(
  parameter int NUM_MASTERS    = 2,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CW             = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [NUM_MASTERS-1:0]    m_cyc_i,
  input  logic [NUM_MASTERS-1:0]    m_stb_i,
  input  logic [NUM_MASTERS-1:0]    m_we_i,
  input  logic [24*NUM_MASTERS-1:0] m_adr_i,
  input  logic [8*NUM_MASTERS-1:0]  m_dat_i,
  output logic [NUM_MASTERS-1:0]    m_ack_o,
  output logic [NUM_MASTERS-1:0]    m_err_o,
  output logic [7:0]                m_dat_o,
  output logic                      s_cyc_o,
  output logic                      s_stb_o,
  output logic                      s_we_o,
  output logic [23:0]               s_adr_o,
  output logic [7:0]                s_dat_o,
  input  logic                      s_ack_i,
  input  logic                      s_err_i,
  input  logic [7:0]                s_dat_i,
  output logic [1:0]                dbg_state_o,
  output logic [2:0]                dbg_gnt_o,
  output logic [CW-1:0]             dbg_wd_o
);

  localparam int GW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_ABORT = 2'd2;

  logic [1:0]    r_state;
  logic [GW-1:0] r_gnt;
  logic [GW-1:0] r_last;
  logic [CW-1:0] r_wd;

  logic          w_granted;
  logic          w_cyc;
  logic          w_stb;
  logic          w_we;
  logic [23:0]   w_adr;
  logic [7:0]    w_dat;
  logic          w_timeout;
  logic [GW-1:0] w_pick;

  // Signals of the currently granted master.
  always_comb begin
    w_cyc = 1'b0;
    w_stb = 1'b0;
    w_we  = 1'b0;
    w_adr = '0;
    w_dat = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (r_gnt == GW'(k)) begin
        w_cyc = m_cyc_i[k];
        w_stb = m_stb_i[k];
        w_we  = m_we_i[k];
        w_adr = m_adr_i[24*k +: 24];
        w_dat = m_dat_i[8*k +: 8];
      end
    end
  end

  // Round-robin pick: scan last+N down to last+1 so the nearest requester
  // after last is written last and wins.
  always_comb begin
    w_pick = r_last;
    for (int i = NUM_MASTERS; i >= 1; i--) begin
      for (int k = 0; k < NUM_MASTERS; k++) begin
        if (k == ((int'(r_last) + i) % NUM_MASTERS) && m_cyc_i[k]) begin
          w_pick = GW'(k);
        end
      end
    end
  end

  assign w_granted = (r_state == ST_GRANT);

  // Timeout fires on the TIMEOUT_CYCLES-th stalled strobe cycle; an ack or
  // slave error in that same cycle takes precedence.
  assign w_timeout = w_granted && w_cyc && w_stb && !s_ack_i && !s_err_i &&
                     (r_wd == CW'(TIMEOUT_CYCLES - 1));

  assign s_cyc_o = w_granted & w_cyc;
  assign s_stb_o = w_granted & w_stb;
  assign s_we_o  = w_granted & w_we;
  assign s_adr_o = w_granted ? w_adr : '0;
  assign s_dat_o = w_granted ? w_dat : '0;
  assign m_dat_o = s_dat_i;

  always_comb begin
    m_ack_o = '0;
    m_err_o = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (w_granted && r_gnt == GW'(k)) begin
        m_ack_o[k] = s_ack_i;
        m_err_o[k] = s_err_i | w_timeout;
      end
    end
  end

  assign dbg_state_o = r_state;
  assign dbg_gnt_o   = 3'(r_gnt);
  assign dbg_wd_o    = r_wd;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_IDLE;
      r_gnt   <= '0;
      r_last  <= GW'(NUM_MASTERS - 1);
      r_wd    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_wd <= '0;
          if (|m_cyc_i) begin
            r_gnt   <= w_pick;
            r_state <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (!w_cyc) begin
            r_last  <= r_gnt;
            r_wd    <= '0;
            r_state <= ST_IDLE;
          end else begin
            if (w_stb && !s_ack_i && !s_err_i) r_wd <= r_wd + CW'(1);
            else                               r_wd <= '0;
            if (w_timeout) r_state <= ST_ABORT;
          end
        end
        ST_ABORT: begin
          r_last  <= r_gnt;
          r_wd    <= '0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_wd    <= '0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_spi_arbiter.sv
// Directed testbench for wb_spi_arbiter (2 masters, 8-cycle watchdog).
module tb_wb_spi_arbiter;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_ABORT = 2'd2;

  // Clock / reset
  logic clk_i = 1'b0;
  logic rst_ni;
  always #5 clk_i = ~clk_i;

  logic [1:0]  m_cyc_i, m_stb_i, m_we_i;
  logic [47:0] m_adr_i;
  logic [15:0] m_dat_i;
  logic [1:0]  m_ack_o, m_err_o;
  logic [7:0]  m_dat_o;
  logic        s_cyc_o, s_stb_o, s_we_o;
  logic [23:0] s_adr_o;
  logic [7:0]  s_dat_o;
  logic        s_ack_i, s_err_i;
  logic [7:0]  s_dat_i;
  logic [1:0]  dbg_state_o;
  logic [2:0]  dbg_gnt_o;
  logic [15:0] dbg_wd_o;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  wb_spi_arbiter #(.NUM_MASTERS(2), .TIMEOUT_CYCLES(8), .CW(16)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
    .m_adr_i(m_adr_i), .m_dat_i(m_dat_i),
    .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_dat_o(m_dat_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o),
    .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_dat_i(s_dat_i),
    .dbg_state_o(dbg_state_o), .dbg_gnt_o(dbg_gnt_o), .dbg_wd_o(dbg_wd_o)
  );

  // Driver tasks
  task automatic next_cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_inputs();
    m_cyc_i = '0; m_stb_i = '0; m_we_i = '0;
    m_adr_i = '0; m_dat_i = '0;
    s_ack_i = 1'b0; s_err_i = 1'b0; s_dat_i = '0;
  endtask

  task automatic apply_reset();
    rst_ni = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    m_cyc_i = 2'b11; m_stb_i = 2'b11; m_we_i = 2'b11;
    m_adr_i = {24'hABCDEF, 24'h123456}; m_dat_i = 16'h7E81;
    s_ack_i = 1'b1; s_err_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    n_checks++;
    if ({s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, m_ack_o, m_err_o} !== 39'd0) begin
      n_errors++;
      $display("FAIL reset_outputs: got cyc=%b stb=%b we=%b adr=%h dat=%h ack=%b err=%b, expected all 0",
               s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, m_ack_o, m_err_o);
    end
    n_checks++;
    if ({dbg_state_o, dbg_gnt_o, dbg_wd_o} !== 21'd0) begin
      n_errors++;
      $display("FAIL reset_state: got state=%0d gnt=%0d wd=%0d, expected 0 0 0",
               dbg_state_o, dbg_gnt_o, dbg_wd_o);
    end
    // Idle with no requests but a stray slave ack/err: nothing forwarded.
    m_cyc_i = '0; m_stb_i = '0;
    rst_ni = 1'b1;
    next_cyc();
    @(negedge clk_i);
    n_checks++;
    if ({dbg_state_o, s_cyc_o, m_ack_o, m_err_o} !== {ST_IDLE, 1'b0, 2'b00, 2'b00}) begin
      n_errors++;
      $display("FAIL idle_quiet: got state=%0d cyc=%b ack=%b err=%b, expected 0 0 00 00",
               dbg_state_o, s_cyc_o, m_ack_o, m_err_o);
    end
  endtask

  task automatic test_single_read();
    apply_reset();
    m_cyc_i = 2'b01; m_stb_i = 2'b01; m_we_i = 2'b00;
    m_adr_i[23:0] = 24'h123456;
    #1;
    n_checks++;
    if ({dbg_state_o, s_cyc_o} !== {ST_IDLE, 1'b0}) begin
      n_errors++;
      $display("FAIL single_arb_cycle: got state=%0d s_cyc=%b, expected 0 0", dbg_state_o, s_cyc_o);
    end
    next_cyc();
    @(negedge clk_i);
    n_checks++;
    if ({dbg_state_o, dbg_gnt_o, s_cyc_o, s_stb_o, s_we_o, s_adr_o, m_ack_o} !==
        {ST_GRANT, 3'd0, 1'b1, 1'b1, 1'b0, 24'h123456, 2'b00}) begin
      n_errors++;
      $display("FAIL single_grant: got state=%0d gnt=%0d cyc=%b stb=%b we=%b adr=%h ack=%b, expected 1 0 1 1 0 123456 00",
               dbg_state_o, dbg_gnt_o, s_cyc_o, s_stb_o, s_we_o, s_adr_o, m_ack_o);
    end
    s_ack_i = 1'b1; s_dat_i = 8'hA5;
    #1;
    n_checks++;
    if ({m_ack_o, m_err_o, m_dat_o} !== {2'b01, 2'b00, 8'hA5}) begin
      n_errors++;
      $display("FAIL single_ack: got ack=%b err=%b dat=%h, expected 01 00 a5", m_ack_o, m_err_o, m_dat_o);
    end
    next_cyc();
    s_ack_i = 1'b0; m_cyc_i = '0; m_stb_i = '0;
    next_cyc();
    @(negedge clk_i);
    n_checks++;
    if ({dbg_state_o, s_cyc_o} !== {ST_IDLE, 1'b0}) begin
      n_errors++;
      $display("FAIL single_release: got state=%0d cyc=%b, expected 0 0", dbg_state_o, s_cyc_o);
    end
  endtask

  task automatic test_round_robin();
    logic g;
    apply_reset();
    m_cyc_i = 2'b11; m_stb_i = 2'b11;
    m_adr_i = {24'h000200, 24'h000100};
    next_cyc();
    for (int i = 0; i < 4; i++) begin
      g = (i % 2 == 1);
      s_ack_i = 1'b1;
      @(negedge clk_i);
      n_checks++;
      if ({dbg_state_o, dbg_gnt_o, m_ack_o, s_adr_o} !==
          {ST_GRANT, (g ? 3'd1 : 3'd0), (g ? 2'b10 : 2'b01), (g ? 24'h000200 : 24'h000100)}) begin
        n_errors++;
        $display("FAIL rr_txn%0d: got state=%0d gnt=%0d ack=%b adr=%h, expected gnt=%0d",
                 i, dbg_state_o, dbg_gnt_o, m_ack_o, s_adr_o, g);
      end
      next_cyc();
      s_ack_i = 1'b0; m_cyc_i[g] = 1'b0; m_stb_i[g] = 1'b0;
      next_cyc();
      // Owner re-requests at once; the other master must still win next.
      m_cyc_i[g] = 1'b1; m_stb_i[g] = 1'b1;
      @(negedge clk_i);
      n_checks++;
      if ({dbg_state_o, s_cyc_o, m_ack_o} !== {ST_IDLE, 1'b0, 2'b00}) begin
        n_errors++;
        $display("FAIL rr_gap%0d: got state=%0d cyc=%b ack=%b, expected 0 0 00",
                 i, dbg_state_o, s_cyc_o, m_ack_o);
      end
      next_cyc();
    end
    clear_inputs();
  endtask

  task automatic test_burst_hold();
    logic [31:0] exp;
    apply_reset();
    exp_q.push_back({24'h000010, 8'h11});
    exp_q.push_back({24'h000011, 8'h22});
    exp_q.push_back({24'h000012, 8'h33});
    m_cyc_i = 2'b10; m_stb_i = 2'b10; m_we_i = 2'b10;
    m_adr_i[47:24] = 24'h000010; m_dat_i[15:8] = 8'h11;
    next_cyc();
    m_cyc_i[0] = 1'b1; m_stb_i[0] = 1'b1; m_adr_i[23:0] = 24'h000300;
    for (int j = 0; j < 3; j++) begin
      m_adr_i[47:24] = 24'h000010 + 24'(j);
      m_dat_i[15:8]  = 8'h11 * 8'(j + 1);
      s_ack_i = 1'b1;
      @(negedge clk_i);
      exp = exp_q.pop_front();
      n_checks++;
      if ({s_adr_o, s_dat_o, s_we_o, m_ack_o} !== {exp, 1'b1, 2'b10}) begin
        n_errors++;
        $display("FAIL burst_write%0d: got adr=%h dat=%h we=%b ack=%b, expected adr=%h dat=%h we=1 ack=10",
                 j, s_adr_o, s_dat_o, s_we_o, m_ack_o, exp[31:8], exp[7:0]);
      end
      next_cyc();
    end
    s_ack_i = 1'b0; m_cyc_i[1] = 1'b0; m_stb_i[1] = 1'b0;
    @(negedge clk_i);
    n_checks++;
    if ({s_cyc_o, m_ack_o} !== {1'b0, 2'b00}) begin
      n_errors++;
      $display("FAIL burst_drop: got cyc=%b ack=%b, expected 0 00", s_cyc_o, m_ack_o);
    end
    next_cyc();
    next_cyc();
    s_ack_i = 1'b1;
    @(negedge clk_i);
    n_checks++;
    if ({dbg_state_o, dbg_gnt_o, m_ack_o, s_adr_o} !== {ST_GRANT, 3'd0, 2'b01, 24'h000300}) begin
      n_errors++;
      $display("FAIL burst_next_owner: got state=%0d gnt=%0d ack=%b adr=%h, expected 1 0 01 000300",
               dbg_state_o, dbg_gnt_o, m_ack_o, s_adr_o);
    end
    n_checks++;
    if (exp_q.size() !== 0) begin
      n_errors++;
      $display("FAIL burst_queue: got %0d leftover, expected 0", exp_q.size());
    end
    clear_inputs();
  endtask

  task automatic test_watchdog();
    apply_reset();
    m_cyc_i = 2'b01; m_stb_i = 2'b01; m_adr_i[23:0] = 24'h000400;
    next_cyc();
    for (int c = 1; c <= 8; c++) begin
      if (c == 3) begin m_cyc_i[1] = 1'b1; m_stb_i[1] = 1'b1; end
      @(negedge clk_i);
      n_checks++;
      if ({s_cyc_o, m_err_o} !== {1'b1, (c == 8) ? 2'b01 : 2'b00}) begin
        n_errors++;
        $display("FAIL wd_cycle%0d: got cyc=%b err=%b, expected err=%b",
                 c, s_cyc_o, m_err_o, (c == 8) ? 2'b01 : 2'b00);
      end
      next_cyc();
    end
    m_cyc_i[0] = 1'b0; m_stb_i[0] = 1'b0;
    s_ack_i = 1'b1; s_err_i = 1'b1;
    @(negedge clk_i);
    n_checks++;
    if ({dbg_state_o, s_cyc_o, s_stb_o, m_ack_o, m_err_o} !== {ST_ABORT, 1'b0, 1'b0, 2'b00, 2'b00}) begin
      n_errors++;
      $display("FAIL wd_abort: got state=%0d cyc=%b stb=%b ack=%b err=%b, expected 2 0 0 00 00",
               dbg_state_o, s_cyc_o, s_stb_o, m_ack_o, m_err_o);
    end
    next_cyc();
    s_ack_i = 1'b0; s_err_i = 1'b0;
    @(negedge clk_i);
    n_checks++;
    if ({dbg_state_o, dbg_wd_o} !== {ST_IDLE, 16'd0}) begin
      n_errors++;
      $display("FAIL wd_idle: got state=%0d wd=%0d, expected 0 0", dbg_state_o, dbg_wd_o);
    end
    next_cyc();
    @(negedge clk_i);
    n_checks++;
    if ({dbg_state_o, dbg_gnt_o, s_cyc_o} !== {ST_GRANT, 3'd1, 1'b1}) begin
      n_errors++;
      $display("FAIL wd_next_owner: got state=%0d gnt=%0d cyc=%b, expected 1 1 1",
               dbg_state_o, dbg_gnt_o, s_cyc_o);
    end
    clear_inputs();
  endtask

  task automatic test_ack_timeout_tie();
    apply_reset();
    m_cyc_i = 2'b01; m_stb_i = 2'b01;
    next_cyc();
    for (int c = 1; c <= 8; c++) begin
      if (c == 8) begin s_ack_i = 1'b1; s_dat_i = 8'h5A; end
      @(negedge clk_i);
      if (c == 8) begin
        n_checks++;
        if ({m_ack_o, m_err_o, m_dat_o} !== {2'b01, 2'b00, 8'h5A}) begin
          n_errors++;
          $display("FAIL tie_ack: got ack=%b err=%b dat=%h, expected 01 00 5a", m_ack_o, m_err_o, m_dat_o);
        end
      end
      next_cyc();
    end
    s_ack_i = 1'b0;
    @(negedge clk_i);
    n_checks++;
    if ({dbg_state_o, dbg_wd_o, s_cyc_o} !== {ST_GRANT, 16'd0, 1'b1}) begin
      n_errors++;
      $display("FAIL tie_no_abort: got state=%0d wd=%0d cyc=%b, expected 1 0 1",
               dbg_state_o, dbg_wd_o, s_cyc_o);
    end
    clear_inputs();
  endtask

  task automatic test_async_reset();
    apply_reset();
    m_cyc_i = 2'b01; m_stb_i = 2'b01;
    next_cyc();
    s_ack_i = 1'b1;
    @(negedge clk_i);
    n_checks++;
    if ({s_cyc_o, m_ack_o} !== {1'b1, 2'b01}) begin
      n_errors++;
      $display("FAIL areset_pre: got cyc=%b ack=%b, expected 1 01", s_cyc_o, m_ack_o);
    end
    #2;
    rst_ni = 1'b0;
    #1;
    n_checks++;
    if ({s_cyc_o, s_stb_o, m_ack_o, dbg_state_o} !== {1'b0, 1'b0, 2'b00, ST_IDLE}) begin
      n_errors++;
      $display("FAIL areset_drop: got cyc=%b stb=%b ack=%b state=%0d, expected 0 0 00 0",
               s_cyc_o, s_stb_o, m_ack_o, dbg_state_o);
    end
    s_ack_i = 1'b0;
    m_cyc_i = 2'b11; m_stb_i = 2'b11;
    @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    next_cyc();
    @(negedge clk_i);
    n_checks++;
    if ({dbg_state_o, dbg_gnt_o} !== {ST_GRANT, 3'd0}) begin
      n_errors++;
      $display("FAIL areset_first_grant: got state=%0d gnt=%0d, expected 1 0", dbg_state_o, dbg_gnt_o);
    end
    clear_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish by 200000 ns, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_ni = 1'b0;
    clear_inputs();
    test_reset();
    test_single_read();
    test_round_robin();
    test_burst_hold();
    test_watchdog();
    test_ack_timeout_tie();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
